// File: rtl/ps2_keycode_tracker_if.sv
// PS/2 keyboard pins and the held-key outputs bundled for the keycode tracker.
// The keyboard side drives the raw PS/2 lines; the tracker drives the key state.
interface ps2_keycode_tracker_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] keycode;
    logic        key_event;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  key_event,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output key_event,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode_tracker.sv
// PS/2 scan-code set 2 receiver that keeps up to four held keys as USB HID usages.
// Each byte of keycode is one slot; prefixes E0/F0 select extended keys and releases.
module ps2_keycode_tracker #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    ps2_keycode_tracker_if.slave  bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    function automatic logic odd_weight(input logic [7:0] b, input logic p);
        return (^{b, p}) == 1'b1;
    endfunction

    function automatic logic [7:0] hid_usage(input logic ext, input logic [7:0] code);
        logic [7:0] u;
        case ({ext, code})
            9'h01C:  u = 8'h04;
            9'h023:  u = 8'h07;
            9'h01D:  u = 8'h1A;
            9'h01B:  u = 8'h16;
            9'h029:  u = 8'h2C;
            9'h05A:  u = 8'h28;
            9'h076:  u = 8'h29;
            9'h16B:  u = 8'h50;
            9'h174:  u = 8'h4F;
            9'h175:  u = 8'h52;
            9'h172:  u = 8'h51;
            default: u = 8'h00;
        endcase
        return u;
    endfunction

    // An already-held usage is ignored; a new one takes the lowest empty slot or is dropped.
    function automatic logic [31:0] press_key(input logic [31:0] kc, input logic [7:0] u);
        logic [31:0] r;
        logic        done;
        r    = kc;
        done = (u == 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (kc[i*8 +: 8] == u) begin
                done = 1'b1;
            end else begin
                done = done;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!done && (kc[i*8 +: 8] == 8'h00)) begin
                r[i*8 +: 8] = u;
                done        = 1'b1;
            end else begin
                done = done;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] release_key(input logic [31:0] kc, input logic [7:0] u);
        logic [31:0] r;
        r = kc;
        for (int i = 0; i < 4; i++) begin
            if ((u != 8'h00) && (kc[i*8 +: 8] == u)) begin
                r[i*8 +: 8] = 8'h00;
            end else begin
                r[i*8 +: 8] = kc[i*8 +: 8];
            end
        end
        return r;
    endfunction

    logic           clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           strobe_s;
    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           timeout_s;
    logic           byte_rdy_q, byte_rdy_d;
    logic           frame_err_q, frame_err_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [31:0]    keycode_q, keycode_d;
    logic           key_event_q, key_event_d;
    logic [7:0]     usage_s;

    // Two-flop synchronisers; both lines idle high.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= bus.ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= bus.ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Glitch filter; the strobe fires on the cycle the filtered level falls.
    always_comb begin
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;
        strobe_s = 1'b0;
        if (clk_sync_q == filt_q) begin
            fcnt_d = {FCW{1'b0}};
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d   = clk_sync_q;
            fcnt_d   = {FCW{1'b0}};
            strobe_s = filt_q;
        end else begin
            fcnt_d = fcnt_q + FCW'(1);
        end
    end

    // Filter state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_q <= 1'b1;
            fcnt_q <= {FCW{1'b0}};
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shifter and inter-strobe timeout; a strobe outranks a timeout.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tcnt_d    = tcnt_q;
        timeout_s = 1'b0;
        if (strobe_s) begin
            tcnt_d = {TCW{1'b0}};
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_sync_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                timeout_s = 1'b1;
                state_d   = ST_IDLE;
                tcnt_d    = {TCW{1'b0}};
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
        end else begin
            tcnt_d = {TCW{1'b0}};
        end
    end

    // FSM outputs: byte-ready or error from the stop bit, error from timeout.
    always_comb begin
        byte_rdy_d  = 1'b0;
        frame_err_d = timeout_s;
        if (strobe_s && (state_q == ST_STOP)) begin
            if (data_sync_q && odd_weight(shift_q, parity_q)) begin
                byte_rdy_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            byte_rdy_d = 1'b0;
        end
    end

    // Frame datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tcnt_q      <= {TCW{1'b0}};
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tcnt_q      <= tcnt_d;
            byte_rdy_q  <= byte_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte decode; shift_q still holds the completed byte while byte_rdy_q is high.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        keycode_d = keycode_q;
        usage_s   = 8'h00;
        if (byte_rdy_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                usage_s   = hid_usage(ext_q, shift_q);
                keycode_d = brk_q ? release_key(keycode_q, usage_s)
                                  : press_key(keycode_q, usage_s);
                ext_d     = 1'b0;
                brk_d     = 1'b0;
            end
        end else if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else begin
            usage_s = 8'h00;
        end
        key_event_d = (keycode_d != keycode_q);
    end

    // Key state and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= 32'h0000_0000;
            key_event_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            key_event_q <= key_event_d;
        end
    end

    assign bus.keycode   = keycode_q;
    assign bus.key_event = key_event_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_tracker.sv
// Directed bench for ps2_keycode_tracker: emulates a keyboard sending set-2 frames
// and compares keycode, key_event and frame_err against hand-computed values.
module tb_ps2_keycode_tracker;
    localparam int HALF = 20;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   ev_cnt  = 0;
    int   err_cnt = 0;

    ps2_keycode_tracker_if bus_if ();

    ps2_keycode_tracker #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_if)
    );

    always #5 Clk = ~Clk;

    // Running pulse counters; tests take differences.
    always @(negedge Clk) begin
        if (bus_if.key_event === 1'b1) ev_cnt <= ev_cnt + 1;
        if (bus_if.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset_n         = 1'b0;
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        tick(3);
        Reset_n = 1'b1;
        tick(20);
    endtask

    // Sends bits[0..nbits-1] as PS/2 bit cells; reports the first pulse cycle in the last cell.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             output int ev_idx, output int err_idx);
        ev_idx  = 0;
        err_idx = 0;
        for (int i = 0; i < nbits; i++) begin
            bus_if.ps2_data = bits[i];
            tick(HALF);
            bus_if.ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                tick(1);
                if (i == nbits - 1) begin
                    if (bus_if.key_event === 1'b1 && ev_idx == 0) ev_idx = k;
                    if (bus_if.frame_err === 1'b1 && err_idx == 0) err_idx = k;
                end
            end
            bus_if.ps2_clk = 1'b1;
        end
        bus_if.ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              output int ev_idx, output int err_idx);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11, ev_idx, err_idx);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int e1, e2;
        send_frame(b, 1'b0, 1'b0, e1, e2);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL reset_keycode got %h want %h", bus_if.keycode, 32'h0);
        end
        n_vec++;
        if (bus_if.key_event !== 1'b0) begin
            n_bad++; $display("FAIL reset_key_event got %b want 0", bus_if.key_event);
        end
        n_vec++;
        if (bus_if.frame_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_frame_err got %b want 0", bus_if.frame_err);
        end
    endtask

    task automatic test_make_break();
        int e0, ev_idx, err_idx;
        do_reset();
        e0 = ev_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, ev_idx, err_idx);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0004) begin
            n_bad++; $display("FAIL make_a keycode got %h want %h", bus_if.keycode, 32'h4);
        end
        n_vec++;
        if (ev_idx !== 11) begin
            n_bad++; $display("FAIL make_a_latency got %0d want 11", ev_idx);
        end
        n_vec++;
        if (err_idx !== 0) begin
            n_bad++; $display("FAIL make_a_no_err got %0d want 0", err_idx);
        end
        send_byte(8'hF0);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0004) begin
            n_bad++; $display("FAIL prefix_f0_nochange got %h want %h", bus_if.keycode, 32'h4);
        end
        send_byte(8'h1C);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL break_a keycode got %h want %h", bus_if.keycode, 32'h0);
        end
        n_vec++;
        if (ev_cnt - e0 !== 2) begin
            n_bad++; $display("FAIL make_break_events got %0d want 2", ev_cnt - e0);
        end
    endtask

    task automatic test_slots();
        do_reset();
        send_byte(8'h1C); send_byte(8'h23); send_byte(8'h1D);
        n_vec++;
        if (bus_if.keycode !== 32'h001A_0704) begin
            n_bad++; $display("FAIL adw keycode got %h want %h", bus_if.keycode, 32'h001A0704);
        end
        send_byte(8'hF0); send_byte(8'h23);
        n_vec++;
        if (bus_if.keycode !== 32'h001A_0004) begin
            n_bad++; $display("FAIL release_d keycode got %h want %h", bus_if.keycode, 32'h001A0004);
        end
        send_byte(8'h1B);
        n_vec++;
        if (bus_if.keycode !== 32'h001A_1604) begin
            n_bad++; $display("FAIL refill_s keycode got %h want %h", bus_if.keycode, 32'h001A1604);
        end
    endtask

    task automatic test_full();
        int e0;
        do_reset();
        e0 = ev_cnt;
        send_byte(8'h1C); send_byte(8'h23); send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h29);
        n_vec++;
        if (bus_if.keycode !== 32'h161A_0704) begin
            n_bad++; $display("FAIL full keycode got %h want %h", bus_if.keycode, 32'h161A0704);
        end
        n_vec++;
        if (ev_cnt - e0 !== 4) begin
            n_bad++; $display("FAIL full_events got %0d want 4", ev_cnt - e0);
        end
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h29);
        n_vec++;
        if (ev_cnt - e0 !== 4) begin
            n_bad++; $display("FAIL repeat_and_unheld_events got %0d want 4", ev_cnt - e0);
        end
        n_vec++;
        if (bus_if.keycode !== 32'h161A_0704) begin
            n_bad++; $display("FAIL repeat_keycode got %h want %h", bus_if.keycode, 32'h161A0704);
        end
    endtask

    task automatic test_extended();
        int e0;
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0052) begin
            n_bad++; $display("FAIL ext_up_make got %h want %h", bus_if.keycode, 32'h52);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL ext_up_break got %h want %h", bus_if.keycode, 32'h0);
        end
        e0 = ev_cnt;
        send_byte(8'h75); send_byte(8'hAA); send_byte(8'hE0); send_byte(8'h1C);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL unmapped_keycode got %h want %h", bus_if.keycode, 32'h0);
        end
        n_vec++;
        if (ev_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL unmapped_events got %0d want 0", ev_cnt - e0);
        end
        send_byte(8'hE0); send_byte(8'h6B); send_byte(8'hE0); send_byte(8'h72);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_5150) begin
            n_bad++; $display("FAIL ext_left_down got %h want %h", bus_if.keycode, 32'h5150);
        end
    endtask

    task automatic test_frame_err();
        int e0, ev_idx, err_idx;
        do_reset();
        send_byte(8'h1C);
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, ev_idx, err_idx);
        n_vec++;
        if (err_idx !== 10) begin
            n_bad++; $display("FAIL parity_err_latency got %0d want 10", err_idx);
        end
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0004) begin
            n_bad++; $display("FAIL parity_err_keycode got %h want %h", bus_if.keycode, 32'h4);
        end
        send_byte(8'hF0); send_byte(8'h1C);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL break_after_err got %h want %h", bus_if.keycode, 32'h0);
        end
        send_byte(8'hE0);
        send_frame(8'h12, 1'b0, 1'b1, ev_idx, err_idx);
        send_byte(8'h75);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000) begin
            n_bad++; $display("FAIL ext_cleared_by_err got %h want %h", bus_if.keycode, 32'h0);
        end
        send_byte(8'hF0);
        send_frame(8'h12, 1'b1, 1'b0, ev_idx, err_idx);
        send_byte(8'h23);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0007) begin
            n_bad++; $display("FAIL brk_cleared_by_err got %h want %h", bus_if.keycode, 32'h7);
        end
        n_vec++;
        if (err_cnt - e0 !== 3) begin
            n_bad++; $display("FAIL frame_err_count got %0d want 3", err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int e0, ev_idx, err_idx;
        do_reset();
        e0 = err_cnt;
        send_bits(11'b000_0000_0110, 4, ev_idx, err_idx);
        tick(300);
        n_vec++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL timeout_err_count got %0d want 1", err_cnt - e0);
        end
        send_byte(8'h23);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0007) begin
            n_bad++; $display("FAIL after_timeout keycode got %h want %h", bus_if.keycode, 32'h7);
        end
        n_vec++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL after_timeout_err_count got %0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_glitch();
        int e0;
        do_reset();
        e0 = err_cnt;
        bus_if.ps2_data = 1'b0;
        tick(HALF);
        bus_if.ps2_clk = 1'b0;
        tick(7);
        bus_if.ps2_clk = 1'b1;
        tick(HALF);
        bus_if.ps2_data = 1'b1;
        tick(HALF);
        send_byte(8'h1C);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0004) begin
            n_bad++; $display("FAIL glitch_keycode got %h want %h", bus_if.keycode, 32'h4);
        end
        n_vec++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL glitch_err_count got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_reset_midframe();
        int e0, ev_idx, err_idx;
        do_reset();
        send_byte(8'h1C);
        send_bits(11'b110_0010_0110, 5, ev_idx, err_idx);
        bus_if.ps2_clk = 1'b0;
        tick(HALF);
        Reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0000 || bus_if.key_event !== 1'b0 ||
            bus_if.frame_err !== 1'b0) begin
            n_bad++; $display("FAIL midframe_reset got %h/%b/%b want 0/0/0",
                              bus_if.keycode, bus_if.key_event, bus_if.frame_err);
        end
        tick(2);
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        tick(3);
        Reset_n = 1'b1;
        tick(20);
        e0 = err_cnt;
        send_byte(8'h23);
        tick(300);
        n_vec++;
        if (bus_if.keycode !== 32'h0000_0007) begin
            n_bad++; $display("FAIL after_reset keycode got %h want %h", bus_if.keycode, 32'h7);
        end
        n_vec++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL after_reset_err_count got %0d want 0", err_cnt - e0);
        end
    endtask

    initial begin
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        test_reset();
        test_make_break();
        test_slots();
        test_full();
        test_extended();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
